// File: rtl/cms_pkg.sv
// Shared constants and types for the CMS AXI-Stream unpacker.
// Also holds the width-legality check used at elaboration.
package cms_pkg;

  localparam int AXI_DATA_WIDTH = 1024;
  localparam int XLEN           = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } cms_unpack_state_t;

  // The wide word must split into a whole number (at least two) of narrow beats.
  function automatic bit cms_widths_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
  endfunction

endpackage

// File: rtl/cms_stat_counter.sv
// 64-bit statistics counter; clear takes priority over increment.
module cms_stat_counter
  import cms_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            clear,
  output logic [XLEN-1:0] count
);

  logic [XLEN-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cms_axis_unpacker.sv
// Serialises one wide AXI-Stream packet into RATIO narrow beats, lowest slice first,
// with tlast propagation, upstream back-pressure and packet/stall statistics.
module cms_axis_unpacker
  import cms_pkg::*;
#(
  parameter  int IN_WIDTH  = AXI_DATA_WIDTH,
  parameter  int OUT_WIDTH = XLEN,
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int BIW       = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  input  logic                 clear_counters,
  output logic                 busy,
  output logic [BIW-1:0]       beat_index,
  output logic [63:0]          pkt_count,
  output logic [63:0]          stall_count
);

  localparam logic [BIW-1:0] LAST_BEAT = BIW'(RATIO - 1);

  if (!cms_widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_width_check
    $error("cms_axis_unpacker: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  cms_unpack_state_t     r_state;
  cms_unpack_state_t     w_state_next;
  logic [IN_WIDTH-1:0]   r_buf;
  logic                  r_last;
  logic [BIW-1:0]        r_beat;

  logic                  w_s_tready;
  logic                  w_m_tvalid;
  logic                  w_s_hs;
  logic                  w_m_hs;
  logic                  w_last_beat;
  logic [OUT_WIDTH-1:0]  w_slice [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_slice
      assign w_slice[gi] = r_buf[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_s_hs      = S_AXIS_tvalid && w_s_tready;
  assign w_m_hs      = w_m_tvalid && M_AXIS_tready;

  always_comb begin
    w_state_next = r_state;
    w_s_tready   = 1'b0;
    w_m_tvalid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_s_tready = 1'b1;
        if (S_AXIS_tvalid) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        w_m_tvalid = 1'b1;
        // Accepting the next packet while the last beat leaves keeps the stream gap-free.
        w_s_tready = w_last_beat && M_AXIS_tready;
        if (M_AXIS_tready && w_last_beat && !S_AXIS_tvalid) begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_last  <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_s_hs) begin
        r_buf  <= S_AXIS_tdata;
        r_last <= S_AXIS_tlast;
        r_beat <= '0;
      end else if (w_m_hs && !w_last_beat) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign S_AXIS_tready = w_s_tready;
  assign M_AXIS_tvalid = w_m_tvalid;
  assign M_AXIS_tdata  = w_slice[r_beat];
  assign M_AXIS_tlast  = (r_state == SEND) && r_last && w_last_beat;
  assign busy          = (r_state == SEND);
  assign beat_index    = r_beat;

  cms_stat_counter u_pkt_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_s_hs),
    .clear (clear_counters),
    .count (pkt_count)
  );

  cms_stat_counter u_stall_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_m_tvalid && !M_AXIS_tready),
    .clear (clear_counters),
    .count (stall_count)
  );

endmodule
